// File: rtl/add_sched.sv
// rtl/add_sched.sv - two-requester round-robin adder sharing one byte-serial 8-bit slice

module add_sched_slice (
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic       i_cin,
    output logic [7:0] o_s,
    output logic       o_cout
);
    assign {o_cout, o_s} = {1'b0, i_a} + {1'b0, i_b} + {8'b0, i_cin};
endmodule

module add_sched #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [8*NBYTES-1:0]   req0_a,
    input  logic [8*NBYTES-1:0]   req0_b,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [8*NBYTES-1:0]   req1_a,
    input  logic [8*NBYTES-1:0]   req1_b,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic                  resp_id,
    output logic [8*NBYTES-1:0]   resp_sum,
    output logic                  resp_cout
);
    localparam int W    = 8 * NBYTES;
    localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_last;
    logic [W-1:0]      r_a;
    logic [W-1:0]      r_b;
    logic [W-1:0]      r_acc;
    logic [W-1:0]      r_sum;
    logic [IDXW-1:0]   r_idx;
    logic              r_carry;
    logic              r_cout;
    logic              r_id;
    logic              r_resp_id;

    logic              w_accept;
    logic              w_grant_id;
    logic              w_last_byte;
    logic [7:0]        w_a_byte;
    logic [7:0]        w_b_byte;
    logic [7:0]        w_s;
    logic              w_cout;
    logic [W-1:0]      w_acc_next;

    assign w_last_byte = (r_idx == IDXW'(NBYTES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Contested grant goes to whoever did not win last; single requester always wins.
    always_comb begin
        w_next     = r_state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        resp_valid = 1'b0;
        w_accept   = 1'b0;
        w_grant_id = (req0_valid && req1_valid) ? ~r_last : req1_valid;
        case (r_state)
            IDLE: begin
                if (!reset && (req0_valid || req1_valid)) begin
                    req0_ready = ~w_grant_id;
                    req1_ready = w_grant_id;
                    w_accept   = 1'b1;
                    w_next     = ADD;
                end
            end
            ADD: begin
                if (w_last_byte) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                resp_valid = ~reset;
                if (resp_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_a_byte = 8'h00;
        w_b_byte = 8'h00;
        for (int i = 0; i < NBYTES; i++) begin
            if (r_idx == IDXW'(i)) begin
                w_a_byte = r_a[i*8 +: 8];
                w_b_byte = r_b[i*8 +: 8];
            end
        end
    end

    add_sched_slice u_slice (
        .i_a    (w_a_byte),
        .i_b    (w_b_byte),
        .i_cin  (r_carry),
        .o_s    (w_s),
        .o_cout (w_cout)
    );

    always_comb begin
        w_acc_next = r_acc;
        for (int i = 0; i < NBYTES; i++) begin
            if (r_idx == IDXW'(i)) begin
                w_acc_next[i*8 +: 8] = w_s;
            end
        end
    end

    // Partial sums build in r_acc so the visible result only changes on entry to DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last    <= 1'b1;
            r_a       <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            r_sum     <= '0;
            r_idx     <= '0;
            r_carry   <= 1'b0;
            r_cout    <= 1'b0;
            r_id      <= 1'b0;
            r_resp_id <= 1'b0;
        end else if (r_state == IDLE && w_accept) begin
            r_a     <= w_grant_id ? req1_a : req0_a;
            r_b     <= w_grant_id ? req1_b : req0_b;
            r_id    <= w_grant_id;
            r_last  <= w_grant_id;
            r_acc   <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
        end else if (r_state == ADD) begin
            r_acc   <= w_acc_next;
            r_carry <= w_cout;
            r_idx   <= r_idx + IDXW'(1);
            if (w_last_byte) begin
                r_sum     <= w_acc_next;
                r_cout    <= w_cout;
                r_resp_id <= r_id;
            end
        end
    end

    assign resp_sum  = r_sum;
    assign resp_cout = r_cout;
    assign resp_id   = r_resp_id;

endmodule
